ar_tag_allocator: RTL and testbench
===================================

Name: ar_tag_allocator

Overview:
- Consumes buffered AR requests from the incoming request buffer.
- Allocates a unique internal tag from a pool of 2^TAG_WIDTH tags and stamps a per-ID sequence number on each request.
- Forwards the request downstream with the AXI ID replaced by the tag.
- Reports each allocation to the reorder buffer, which releases the tag when the burst has fully retired to the master.

Parameters:
- ID_WIDTH, 4, AXI master ID width
- ADDR_WIDTH, 32, address width
- LEN_WIDTH, 8, burst length width
- TAG_WIDTH, 4, internal tag width; pool size NUM_TAGS = 2^TAG_WIDTH
- SEQ_WIDTH, 4, per-ID sequence counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid from upstream buffer
- in_ready  out  1  request accepted this cycle when in_valid=1
- in_id  in  ID_WIDTH  original AXI ID
- in_addr  in  ADDR_WIDTH  burst address
- in_len  in  LEN_WIDTH  burst length (beats-1)
- in_size  in  3  beat size
- in_burst  in  2  burst type
- in_qos  in  4  QoS
- out_valid  out  1  registered request to slave side
- out_ready  in  1  downstream accept
- out_tag  out  TAG_WIDTH  allocated tag, used as downstream ARID
- out_addr, out_len, out_size, out_burst, out_qos  out  (as input)  registered copies of request fields
- alloc_valid  out  1  one-cycle pulse, allocation record valid
- alloc_tag  out  TAG_WIDTH  allocated tag
- alloc_id  out  ID_WIDTH  original ID bound to tag
- alloc_seq  out  SEQ_WIDTH  per-ID sequence number
- alloc_len  out  LEN_WIDTH  burst length
- free_valid  in  1  release request from ROB
- free_tag  in  TAG_WIDTH  tag to release
- tags_used  out  TAG_WIDTH+1  count of busy tags
- free_err  out  1  sticky illegal-free flag (optional feature)

Behaviour:
- Reset values:
  - out_valid=0, alloc_valid=0, tags_used=0, free_err=0; all data outputs 0.
  - busy vector all 0; all per-ID seq counters 0.
- Internal state:
  - busy[NUM_TAGS]: registered tag-busy vector.
  - seq[2^ID_WIDTH]: per-ID counters.
- Handshake and acceptance:
  - can_load = ~out_valid | out_ready.
  - tag_avail = some busy bit is 0, evaluated on the registered vector.
  - in_ready = tag_avail & can_load, a combinational function of state and out_ready only; it does not depend on in_valid.
  - accept = in_valid & in_ready.
- Tag selection: lowest-index free tag (priority encoder on ~busy).
- On accept, at the next edge:
  - busy[sel]=1.
  - Output register loads all fields with out_tag=sel; out_valid=1.
  - alloc_valid=1 with alloc_tag=sel, alloc_id=in_id, alloc_seq=seq[in_id], alloc_len=in_len.
  - seq[in_id] increments, wrapping modulo 2^SEQ_WIDTH.
- Latency: one cycle from accept to out_valid and alloc_valid, which occur in the same cycle.
- Without accept:
  - alloc_valid=0.
  - If out_valid & out_ready, out_valid drops to 0; otherwise the output register holds.
- Release:
  - free_valid with busy[free_tag]=1 clears that bit at the next edge.
  - A freed tag is not allocatable in the same cycle (no bypass); it is eligible from the following cycle.
- Simultaneous alloc and free in one cycle: both apply. They are necessarily different tags, since the allocated tag was free.
- tags_used equals the popcount of busy, as a registered counter: +1 on accept, −1 on valid free, unchanged when both occur.
- Pool full (tags_used=NUM_TAGS): in_ready=0; request fields must be held stable upstream.
- Back-to-back: a sustained stream is accepted every cycle while out_ready=1 and tags remain.
- Reset mid-operation: all tags return to free, counters clear, and pending output is dropped. The ROB is reset in the same cycle.

Optional Feature:
- Macro: AR_TAG_ALLOC_FREE_CHECK_EN.
- Defined:
  - free_valid on a non-busy tag is ignored (no state change, tags_used unchanged).
  - free_err sets and stays 1 until rst.
- Undefined:
  - No illegal-free check; free_err is tied 0.
  - Freeing a non-busy tag leaves busy unchanged and decrements tags_used anyway. Legal use by the ROB is required.

Test Plan:
- Single request: after reset, in_id=3, addr=0x100, len=7 -> next cycle out_valid=1, out_tag=0, alloc_valid=1, alloc_id=3, alloc_seq=0, tags_used=1.
- Per-ID sequencing: three requests with id=5 and one with id=2, out_ready=1 -> tags 0,1,2,3; alloc_seq for id 5 = 0,1,2 and for id 2 = 0.
- Pool exhaustion: 16 requests with no frees -> in_ready=0 on the 17th. free_tag=9 -> in_ready=1 the cycle after; the next request gets tag 9.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0 and output fields stable. Raise out_ready -> new request loads in the same edge as the drain.
- Simultaneous free/alloc: tags 0-3 busy, free_tag=1 in the same cycle as accept -> new tag=4, tags_used unchanged at 4, and tag 1 is allocated on the next request.
- Illegal free (macro on): free_tag=7 when tag 7 is not busy -> free_err=1 and sticky, tags_used unchanged. rst -> free_err=0.

Source files
------------

// File: rtl/ar_tag_allocator.sv
// AR tag allocator: binds each accepted read request to the lowest free internal tag and a per-ID sequence number.
// Optional illegal-free checking is enabled with `define AR_TAG_ALLOC_FREE_CHECK_EN.
module ar_tag_allocator #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int TAG_WIDTH  = 4,
    parameter int SEQ_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ID_WIDTH-1:0]   in_id,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [LEN_WIDTH-1:0]  in_len,
    input  logic [2:0]            in_size,
    input  logic [1:0]            in_burst,
    input  logic [3:0]            in_qos,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [LEN_WIDTH-1:0]  out_len,
    output logic [2:0]            out_size,
    output logic [1:0]            out_burst,
    output logic [3:0]            out_qos,
    output logic                  alloc_valid,
    output logic [TAG_WIDTH-1:0]  alloc_tag,
    output logic [ID_WIDTH-1:0]   alloc_id,
    output logic [SEQ_WIDTH-1:0]  alloc_seq,
    output logic [LEN_WIDTH-1:0]  alloc_len,
    input  logic                  free_valid,
    input  logic [TAG_WIDTH-1:0]  free_tag,
    output logic [TAG_WIDTH:0]    tags_used,
    output logic                  free_err
);
    localparam int NUM_TAGS = 1 << TAG_WIDTH;
    localparam int NUM_IDS  = 1 << ID_WIDTH;

    logic [NUM_TAGS-1:0]   busy_q, busy_d;
    logic [SEQ_WIDTH-1:0]  seq_q [NUM_IDS];
    logic [SEQ_WIDTH-1:0]  seq_d [NUM_IDS];
    logic [TAG_WIDTH:0]    tags_used_q, tags_used_d;
    logic                  out_valid_q, out_valid_d;
    logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic [LEN_WIDTH-1:0]  out_len_q, out_len_d;
    logic [2:0]            out_size_q, out_size_d;
    logic [1:0]            out_burst_q, out_burst_d;
    logic [3:0]            out_qos_q, out_qos_d;
    logic                  alloc_valid_q, alloc_valid_d;
    logic [TAG_WIDTH-1:0]  alloc_tag_q, alloc_tag_d;
    logic [ID_WIDTH-1:0]   alloc_id_q, alloc_id_d;
    logic [SEQ_WIDTH-1:0]  alloc_seq_q, alloc_seq_d;
    logic [LEN_WIDTH-1:0]  alloc_len_q, alloc_len_d;

    logic [TAG_WIDTH-1:0]  sel;
    logic                  tag_avail;
    logic                  can_load;
    logic                  accept;
    logic                  free_hit;
    logic                  free_dec;

    // Lowest-index free tag; descending scan lets the lowest hit win.
    always_comb begin
        sel       = '0;
        tag_avail = 1'b0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                sel       = TAG_WIDTH'(i);
                tag_avail = 1'b1;
            end
        end
    end

    assign can_load = ~out_valid_q | out_ready;
    assign in_ready = tag_avail & can_load;
    assign accept   = in_valid & in_ready;
    assign free_hit = free_valid & busy_q[free_tag];

`ifdef AR_TAG_ALLOC_FREE_CHECK_EN
    logic free_err_q, free_err_d;
    assign free_dec   = free_hit;
    assign free_err_d = free_err_q | (free_valid & ~busy_q[free_tag]);
    assign free_err   = free_err_q;

    always_ff @(posedge clk) begin
        if (rst) free_err_q <= 1'b0;
        else     free_err_q <= free_err_d;
    end
`else
    // Without checking, the ROB is trusted: every free counts down.
    assign free_dec = free_valid;
    assign free_err = 1'b0;
`endif

    always_comb begin
        busy_d = busy_q;
        if (free_hit) busy_d[free_tag] = 1'b0;
        if (accept)   busy_d[sel]      = 1'b1;

        tags_used_d = tags_used_q;
        if (accept && !free_dec)      tags_used_d = tags_used_q + (TAG_WIDTH+1)'(1);
        else if (!accept && free_dec) tags_used_d = tags_used_q - (TAG_WIDTH+1)'(1);

        for (int i = 0; i < NUM_IDS; i++) seq_d[i] = seq_q[i];
        if (accept) seq_d[in_id] = seq_q[in_id] + SEQ_WIDTH'(1);

        out_valid_d = out_valid_q;
        out_tag_d   = out_tag_q;
        out_addr_d  = out_addr_q;
        out_len_d   = out_len_q;
        out_size_d  = out_size_q;
        out_burst_d = out_burst_q;
        out_qos_d   = out_qos_q;
        alloc_tag_d = alloc_tag_q;
        alloc_id_d  = alloc_id_q;
        alloc_seq_d = alloc_seq_q;
        alloc_len_d = alloc_len_q;
        alloc_valid_d = accept;
        if (accept) begin
            out_valid_d = 1'b1;
            out_tag_d   = sel;
            out_addr_d  = in_addr;
            out_len_d   = in_len;
            out_size_d  = in_size;
            out_burst_d = in_burst;
            out_qos_d   = in_qos;
            alloc_tag_d = sel;
            alloc_id_d  = in_id;
            alloc_seq_d = seq_q[in_id];
            alloc_len_d = in_len;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= '0;
            for (int i = 0; i < NUM_IDS; i++) seq_q[i] <= '0;
            tags_used_q   <= '0;
            out_valid_q   <= 1'b0;
            out_tag_q     <= '0;
            out_addr_q    <= '0;
            out_len_q     <= '0;
            out_size_q    <= '0;
            out_burst_q   <= '0;
            out_qos_q     <= '0;
            alloc_valid_q <= 1'b0;
            alloc_tag_q   <= '0;
            alloc_id_q    <= '0;
            alloc_seq_q   <= '0;
            alloc_len_q   <= '0;
        end else begin
            busy_q        <= busy_d;
            for (int i = 0; i < NUM_IDS; i++) seq_q[i] <= seq_d[i];
            tags_used_q   <= tags_used_d;
            out_valid_q   <= out_valid_d;
            out_tag_q     <= out_tag_d;
            out_addr_q    <= out_addr_d;
            out_len_q     <= out_len_d;
            out_size_q    <= out_size_d;
            out_burst_q   <= out_burst_d;
            out_qos_q     <= out_qos_d;
            alloc_valid_q <= alloc_valid_d;
            alloc_tag_q   <= alloc_tag_d;
            alloc_id_q    <= alloc_id_d;
            alloc_seq_q   <= alloc_seq_d;
            alloc_len_q   <= alloc_len_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_tag     = out_tag_q;
    assign out_addr    = out_addr_q;
    assign out_len     = out_len_q;
    assign out_size    = out_size_q;
    assign out_burst   = out_burst_q;
    assign out_qos     = out_qos_q;
    assign alloc_valid = alloc_valid_q;
    assign alloc_tag   = alloc_tag_q;
    assign alloc_id    = alloc_id_q;
    assign alloc_seq   = alloc_seq_q;
    assign alloc_len   = alloc_len_q;
    assign tags_used   = tags_used_q;

endmodule

// File: tb/tb_ar_tag_allocator.sv
// Bench for ar_tag_allocator: directed scenarios followed by random traffic, all checked against a behavioural model.
module tb_ar_tag_allocator;
    localparam int IDW = 4, AW = 32, LW = 8, TW = 4, SW = 4;
    localparam int NT = 1 << TW, NI = 1 << IDW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [IDW-1:0] in_id;
    logic [AW-1:0] in_addr;
    logic [LW-1:0] in_len;
    logic [2:0]    in_size;
    logic [1:0]    in_burst;
    logic [3:0]    in_qos;
    logic          out_valid, out_ready;
    logic [TW-1:0] out_tag;
    logic [AW-1:0] out_addr;
    logic [LW-1:0] out_len;
    logic [2:0]    out_size;
    logic [1:0]    out_burst;
    logic [3:0]    out_qos;
    logic          alloc_valid;
    logic [TW-1:0] alloc_tag;
    logic [IDW-1:0] alloc_id;
    logic [SW-1:0] alloc_seq;
    logic [LW-1:0] alloc_len;
    logic          free_valid;
    logic [TW-1:0] free_tag;
    logic [TW:0]   tags_used;
    logic          free_err;

    always #5 clk = ~clk;

    ar_tag_allocator #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAG_WIDTH(TW), .SEQ_WIDTH(SW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_addr(in_addr),
        .in_len(in_len), .in_size(in_size), .in_burst(in_burst), .in_qos(in_qos),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_addr(out_addr),
        .out_len(out_len), .out_size(out_size), .out_burst(out_burst), .out_qos(out_qos),
        .alloc_valid(alloc_valid), .alloc_tag(alloc_tag), .alloc_id(alloc_id),
        .alloc_seq(alloc_seq), .alloc_len(alloc_len),
        .free_valid(free_valid), .free_tag(free_tag), .tags_used(tags_used), .free_err(free_err)
    );

    // Reference model: a set of busy tags, a per-ID request count, and the visible output records.
    bit          m_busy [NT];
    int          m_seq  [NI];
    bit          m_ov, m_av, m_ferr, m_was_rst;
    int          m_otag, m_olen, m_osize, m_oburst, m_oqos;
    logic [AW-1:0] m_oaddr;
    int          m_atag, m_aid, m_aseq, m_alen;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int used_count();
        int n = 0;
        for (int i = 0; i < NT; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NT; i++) m_busy[i] = 0;
        for (int i = 0; i < NI; i++) m_seq[i] = 0;
        m_ov = 0; m_av = 0; m_ferr = 0;
        m_otag = 0; m_oaddr = '0; m_olen = 0; m_osize = 0; m_oburst = 0; m_oqos = 0;
        m_atag = 0; m_aid = 0; m_aseq = 0; m_alen = 0;
    endtask

    // One clock: check in_ready against the model, advance the model, then check registered outputs.
    task automatic cycle();
        int sel;
        bit rdy, acc;
        #1;
        sel = -1;
        for (int i = 0; i < NT; i++) if (!m_busy[i]) begin sel = i; break; end
        rdy = (sel >= 0) && (!m_ov || out_ready);
        m_was_rst = rst;
        if (rst) begin
            model_reset();
        end else begin
            check("in_ready", in_ready, rdy);
            acc = in_valid && rdy;
            if (free_valid) begin
                if (m_busy[free_tag]) m_busy[free_tag] = 0;
`ifdef AR_TAG_ALLOC_FREE_CHECK_EN
                else m_ferr = 1;
`endif
            end
            if (acc) begin
                m_busy[sel] = 1;
                m_ov = 1; m_otag = sel; m_oaddr = in_addr; m_olen = in_len;
                m_osize = in_size; m_oburst = in_burst; m_oqos = in_qos;
                m_atag = sel; m_aid = in_id; m_aseq = m_seq[in_id]; m_alen = in_len;
                m_seq[in_id] = (m_seq[in_id] + 1) % (1 << SW);
            end else if (m_ov && out_ready) begin
                m_ov = 0;
            end
            m_av = acc;
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid, m_ov);
        check("alloc_valid", alloc_valid, m_av);
        check("tags_used", tags_used, used_count());
        check("free_err", free_err, m_ferr);
        check("out_tag", out_tag, m_otag);
        check("out_addr", out_addr, m_oaddr);
        check("out_len", out_len, m_olen);
        check("out_size", out_size, m_osize);
        check("out_burst", out_burst, m_oburst);
        check("out_qos", out_qos, m_oqos);
        if (m_av || m_was_rst) begin
            check("alloc_tag", alloc_tag, m_atag);
            check("alloc_id", alloc_id, m_aid);
            check("alloc_seq", alloc_seq, m_aseq);
            check("alloc_len", alloc_len, m_alen);
        end
    endtask

    task automatic drive(input bit iv, input int id, input logic [AW-1:0] addr, input int len,
                         input bit ordy, input bit fv, input int ft);
        rst        = 1'b0;
        in_valid   = iv;
        in_id      = IDW'(id);
        in_addr    = addr;
        in_len     = LW'(len);
        in_size    = 3'($urandom_range(0, 7));
        in_burst   = 2'($urandom_range(0, 3));
        in_qos     = 4'($urandom_range(0, 15));
        out_ready  = ordy;
        free_valid = fv;
        free_tag   = TW'(ft);
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; free_valid = 1'b0; out_ready = 1'b1;
        in_id = '0; in_addr = '0; in_len = '0; in_size = '0; in_burst = '0; in_qos = '0; free_tag = '0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int busy_list [$];
        model_reset();
        do_reset();
        do_reset();

        // Single request
        drive(1, 3, 32'h100, 7, 1, 0, 0);
        check("tp_single_tag", out_tag, 0);
        check("tp_single_seq", alloc_seq, 0);
        check("tp_single_used", tags_used, 1);
        drive(0, 0, 0, 0, 1, 0, 0);

        // Per-ID sequencing
        do_reset();
        drive(1, 5, 32'h1000, 1, 1, 0, 0);
        drive(1, 5, 32'h1040, 2, 1, 0, 0);
        drive(1, 5, 32'h1080, 3, 1, 0, 0);
        check("tp_seq_id5", alloc_seq, 2);
        drive(1, 2, 32'h2000, 0, 1, 0, 0);
        check("tp_seq_id2", alloc_seq, 0);
        check("tp_seq_tag", alloc_tag, 3);

        // Pool exhaustion and release of tag 9
        do_reset();
        for (int i = 0; i < NT; i++) drive(1, i % NI, 32'(i * 64), i, 1, 0, 0);
        check("tp_full_used", tags_used, NT);
        drive(1, 1, 32'hdead0, 3, 1, 0, 0);
        drive(0, 1, 32'hdead0, 3, 1, 1, 9);
        drive(1, 1, 32'hdead0, 3, 1, 0, 0);
        check("tp_refill_tag", out_tag, 9);

        // Backpressure then drain-and-load on the same edge
        do_reset();
        drive(1, 1, 32'h300, 4, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 2, 32'h400, 5, 0, 0, 0);
        check("tp_bp_addr", out_addr, 32'h300);
        drive(1, 2, 32'h400, 5, 1, 0, 0);
        check("tp_bp_tag", out_tag, 1);

        // Simultaneous free and allocate
        do_reset();
        for (int i = 0; i < 4; i++) drive(1, 7, 32'(i), 0, 1, 0, 0);
        drive(1, 7, 32'h50, 0, 1, 1, 1);
        check("tp_sim_tag", out_tag, 4);
        check("tp_sim_used", tags_used, 4);
        drive(1, 7, 32'h60, 0, 1, 0, 0);
        check("tp_sim_next", out_tag, 1);

`ifdef AR_TAG_ALLOC_FREE_CHECK_EN
        // Illegal free is ignored and flagged until reset
        do_reset();
        drive(1, 0, 32'h10, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 7);
        check("tp_ill_err", free_err, 1);
        check("tp_ill_used", tags_used, 1);
        drive(0, 0, 0, 0, 1, 0, 0);
        check("tp_ill_sticky", free_err, 1);
        do_reset();
        check("tp_ill_clear", free_err, 0);
`endif

        // Random traffic with only legal frees, plus one reset mid-stream
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bit fv;
            int ft;
            if (c == 1500) begin
                do_reset();
                continue;
            end
            busy_list.delete();
            for (int i = 0; i < NT; i++) if (m_busy[i]) busy_list.push_back(i);
            fv = (busy_list.size() > 0) && ($urandom_range(0, 2) == 0);
            ft = fv ? busy_list[$urandom_range(0, busy_list.size() - 1)] : int'($urandom_range(0, NT - 1));
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, NI - 1)), AW'($urandom),
                  int'($urandom_range(0, 255)), $urandom_range(0, 9) < 7, fv, ft);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
